shft_deser: RTL and testbench

- Serial-to-parallel receiver: the far end of the parallel-load / serial-shift register datapath.
- Accepts one bit per strobe, frames WIDTH bits starting at a start-qualified bit, and assembles them in the order selected by dir_sel.
- Presents the completed word on a holding register with a valid/ready handshake.
- Used wherever a serialized word from the shift-register transmitter must be recovered into a parallel bus.

---
 rtl/shft_deser_pkg.sv | 12 +
 rtl/shft_deser_core.sv | 43 ++++
 rtl/shft_deser.sv | 97 +++++++++
 tb/tb_shft_deser.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shft_deser_pkg.sv
// Shared encodings for the serial-to-parallel receiver.
package shft_deser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shft_deser_core.sv
// Shift register plus bit counter; sr_nxt is the word including the bit on s_in.
module shft_deser_core
  import shft_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             dir,
  input  logic             s_in,
  output logic [WIDTH-1:0] sr_nxt,
  output logic             at_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;
  logic [CW-1:0]    cnt;

  // A start bit shifts into a cleared register so no stale bits survive a resync.
  always_comb begin
    base   = clear ? '0 : sr;
    sr_nxt = (dir == DIR_RIGHT) ? {s_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], s_in};
  end

  assign at_last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr <= sr_nxt;
      if (clear)        cnt <= CW'(1);
      else if (at_last) cnt <= '0;
      else              cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shft_deser.sv
// Serial-to-parallel receiver: frames WIDTH bits after a start bit and
// presents the word on a holding register with a valid/ready handshake.
module shft_deser
  import shft_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             s_start,
  input  logic             dir_sel,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  state_t           state, state_nxt;
  logic             dir_q;
  logic             shift_en, clear, complete, ferr_nxt;
  logic             core_dir, at_last;
  logic [WIDTH-1:0] word;

  // The start bit itself must use the live dir_sel; later bits use the latch.
  assign core_dir = clear ? dir_sel : dir_q;

  shft_deser_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (clear),
    .dir      (core_dir),
    .s_in     (s_in),
    .sr_nxt   (word),
    .at_last  (at_last)
  );

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    clear     = 1'b0;
    complete  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid && s_start) begin
          shift_en  = 1'b1;
          clear     = 1'b1;
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (s_valid) begin
          shift_en = 1'b1;
          if (s_start) begin
            clear    = 1'b1;
            ferr_nxt = 1'b1;
          end else if (at_last) begin
            complete  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_q     <= DIR_LEFT;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= ferr_nxt;
      overrun   <= 1'b0;
      if (clear) dir_q <= dir_sel;
      if (complete) begin
        out       <= word;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_RECV);

endmodule

// File: tb/tb_shft_deser.sv
// Directed bench for shft_deser with a frame-level reference model checked every cycle.
module tb_shft_deser;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0, s_in = 1'b0, s_start = 1'b0, dir_sel = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic             out_valid, busy, overrun, frame_err;

  shft_deser #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_in(s_in), .s_start(s_start),
    .dir_sel(dir_sel), .out_ready(out_ready), .out(out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  // Reference model state: bits of the current frame in arrival order.
  logic             m_bits[$];
  logic             m_dir = 1'b0;
  logic             m_busy = 1'b0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out", 32'(out), 32'(m_out));
      cmp("out_valid", 32'(out_valid), 32'(m_valid));
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("overrun", 32'(overrun), 32'(m_ovr));
      cmp("frame_err", 32'(frame_err), 32'(m_ferr));
    end
  end

  function automatic logic [WIDTH-1:0] assemble(input logic d);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d) w[i] = m_bits[i];
      else   w[WIDTH-1-i] = m_bits[i];
    end
    return w;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic step(input logic v, input logic b, input logic st, input logic d, input logic rdy);
    logic done;
    s_valid = v; s_in = b; s_start = st; dir_sel = d; out_ready = rdy;
    @(posedge clk);
    done   = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    if (v) begin
      if (st) begin
        if (m_busy) m_ferr = 1'b1;
        m_bits.delete();
        m_bits.push_back(b);
        m_dir  = d;
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_bits.push_back(b);
        if (m_bits.size() == WIDTH) begin
          m_ovr   = m_valid && !rdy;
          m_out   = assemble(m_dir);
          m_valid = 1'b1;
          m_busy  = 1'b0;
          done    = 1'b1;
        end
      end
    end
    if (!done && m_valid && rdy) m_valid = 1'b0;
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // seq[WIDTH-1] is sent first; non-start bits drive the opposite dir_sel.
  task automatic send_frame(input logic [WIDTH-1:0] seq, input logic d, input int gap, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b1, seq[WIDTH-1-i], (i == 0), (i == 0) ? d : ~d, (i == WIDTH-1) ? rdy_last : 1'b0);
      if (i != WIDTH-1 && gap > 0) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, g[0] ^ d, 1'b0);
      end
    end
  endtask

  initial begin
    #3;
    cmp("reset_out", 32'(out), 32'h0);
    cmp("reset_valid", 32'(out_valid), 32'h0);
    cmp("reset_busy", 32'(busy), 32'h0);
    chk_en = 1'b1;
    #9 reset = 1'b0;

    // MSB-first frame, unconsumed
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("busy_after_bit1", 32'(busy), 32'h1);
    for (int i = 1; i < WIDTH; i++) step(1'b1, (8'b10110010 >> (7 - i)) & 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("msb_first_out", 32'(out), 32'hB2);
    cmp("msb_first_model", 32'(m_out), 32'hB2);
    cmp("busy_after_last", 32'(busy), 32'h0);
    idle(1, 1'b1);
    cmp("consumed", 32'(out_valid), 32'h0);

    // LSB-first frame, consumed one cycle late
    send_frame(8'b10110010, 1'b1, 0, 1'b0);
    cmp("lsb_first_out", 32'(out), 32'h4D);
    idle(1, 1'b0);
    idle(1, 1'b1);
    cmp("lsb_consumed_valid", 32'(out_valid), 32'h0);
    cmp("lsb_consumed_out", 32'(out), 32'h4D);

    // Stray strobe in IDLE, then gapped frame with dir toggling
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("stray_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("start_no_valid_busy", 32'(busy), 32'h0);
    send_frame(8'b10110010, 1'b1, 2, 1'b0);
    cmp("gapped_out", 32'(out), 32'h4D);

    // Overrun, then back-to-back frame completing with a consume
    send_frame(8'b11001111, 1'b0, 0, 1'b0);
    cmp("overrun_pulse", 32'(overrun), 32'h1);
    cmp("overrun_out", 32'(out), 32'hCF);
    send_frame(8'b00010110, 1'b0, 0, 1'b1);
    cmp("swap_no_overrun", 32'(overrun), 32'h0);
    cmp("swap_valid", 32'(out_valid), 32'h1);
    cmp("swap_out", 32'(out), 32'h16);
    idle(1, 1'b1);

    // Resync: 4 bits, then restart with 8 bits
    send_frame(8'b11110000, 1'b1, 0, 1'b0);
    idle(1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'b10011011, 1'b0, 0, 1'b0);
    cmp("resync_out", 32'(out), 32'h9B);

    // Async reset mid-frame with a pending word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b0);
    #2 reset = 1'b1;
    m_bits.delete();
    m_busy = 1'b0; m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_dir = 1'b0;
    #1;
    cmp("async_out", 32'(out), 32'h0);
    cmp("async_valid", 32'(out_valid), 32'h0);
    cmp("async_busy", 32'(busy), 32'h0);
    #4 reset = 1'b0;
    send_frame(8'b11100001, 1'b1, 0, 1'b0);
    cmp("post_reset_out", 32'(out), 32'h87);
    idle(2, 1'b1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
